// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl_pkg
// Description : Shared definitions for the pipeline hazard controller:
//               the load result-select code, the sequencer state encoding
//               and the default performance-counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_hazard_ctrl_pkg;

    // result_sel value that marks a load in the EX stage
    localparam logic [1:0] RESULT_SEL_LOAD   = 2'b01;

    // Default width of the saturating performance counters
    localparam int         CNT_WIDTH_DEFAULT = 32;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } hz_state_e;

endpackage
`default_nettype wire

// File: rtl/hazard_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : hazard_sat_counter
// Description : Event counter that increments on en_i and sticks at
//               all-ones instead of wrapping. Asynchronously cleared.
// Ports       : clk_i   - clock
//               rst_ni  - asynchronous active-low clear
//               en_i    - count this cycle
//               cnt_o   - current count
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_sat_counter
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    output logic [WIDTH-1:0] cnt_o
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + ONE;
        end
    end

    assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Stall/flush sequencer for the five-stage core. Resolves
//               data-memory waits (with watchdog), EX redirects, load-use
//               hazards and a debug halt/drain handshake, and keeps
//               saturating performance counters.
// Ports       : cpu_clk, cpu_rst_n          - clock, async active-low reset
//               rs1_ID/rs2_ID/use_rs*_ID    - ID-stage source operands
//               rd_EX/reg_write_EX/
//               result_sel_EX/redirect_EX   - EX-stage destination and redirect
//               dmem_req_MEM/dmem_ready     - MEM-stage memory handshake
//               halt_req / halt_ack         - debug halt handshake
//               stall_* / flush_*           - pipeline register controls
//               mem_timeout                 - sticky watchdog error
//               stall_cnt/flush_cnt/lu_cnt  - performance counters
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REGISTER_ADDR_WIDTH = 5,
    parameter int DRAIN_CYCLES        = 4,
    parameter int TIMEOUT_CYCLES      = 256,
    parameter int CNT_WIDTH           = CNT_WIDTH_DEFAULT
) (
    input  logic                           cpu_clk,
    input  logic                           cpu_rst_n,
    input  logic [REGISTER_ADDR_WIDTH-1:0] rs1_ID,
    input  logic [REGISTER_ADDR_WIDTH-1:0] rs2_ID,
    input  logic                           use_rs1_ID,
    input  logic                           use_rs2_ID,
    input  logic [REGISTER_ADDR_WIDTH-1:0] rd_EX,
    input  logic                           reg_write_EX,
    input  logic [1:0]                     result_sel_EX,
    input  logic                           redirect_EX,
    input  logic                           dmem_req_MEM,
    input  logic                           dmem_ready,
    input  logic                           halt_req,
    output logic                           stall_PC,
    output logic                           stall_IF_ID,
    output logic                           flush_IF_ID,
    output logic                           stall_ID_EX,
    output logic                           flush_ID_EX,
    output logic                           stall_EX_MEM,
    output logic                           flush_MEM_WB,
    output logic                           halt_ack,
    output logic                           mem_timeout,
    output logic [CNT_WIDTH-1:0]           stall_cnt,
    output logic [CNT_WIDTH-1:0]           flush_cnt,
    output logic [CNT_WIDTH-1:0]           lu_cnt
);

    localparam int DRAIN_W = (DRAIN_CYCLES   > 1) ? $clog2(DRAIN_CYCLES)   : 1;
    localparam int WD_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_ONE  = {{(DRAIN_W-1){1'b0}}, 1'b1};
    localparam logic [WD_W-1:0]    WD_LAST    = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WD_W-1:0]    WD_ONE     = {{(WD_W-1){1'b0}}, 1'b1};

    hz_state_e          state_q, state_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic [WD_W-1:0]    wd_q;
    logic               halt_ack_q;
    logic               mem_timeout_q;

    logic               mem_wait;
    logic               load_use;
    logic               redirect_taken;
    logic               load_use_taken;

    assign mem_wait = dmem_req_MEM & ~dmem_ready;

    // x0 is never a real dependency, so a load to x0 cannot stall
    assign load_use = reg_write_EX
                    & (result_sel_EX == RESULT_SEL_LOAD)
                    & (rd_EX != '0)
                    & ((use_rs1_ID & (rs1_ID == rd_EX)) |
                       (use_rs2_ID & (rs2_ID == rd_EX)));

    // ------------------------------------------------------------------------
    // Next-state and combinational stall/flush controls
    // ------------------------------------------------------------------------
    always_comb begin
        stall_PC       = 1'b0;
        stall_IF_ID    = 1'b0;
        flush_IF_ID    = 1'b0;
        stall_ID_EX    = 1'b0;
        flush_ID_EX    = 1'b0;
        stall_EX_MEM   = 1'b0;
        flush_MEM_WB   = 1'b0;
        redirect_taken = 1'b0;
        load_use_taken = 1'b0;
        state_d        = state_q;
        drain_d        = drain_q;

        case (state_q)
            ST_RUN: begin
                if (mem_wait) begin
                    // EX is frozen, so a pending redirect or load-use is
                    // simply re-presented once memory completes
                    stall_PC     = 1'b1;
                    stall_IF_ID  = 1'b1;
                    stall_ID_EX  = 1'b1;
                    stall_EX_MEM = 1'b1;
                    flush_MEM_WB = 1'b1;
                end else if (redirect_EX) begin
                    flush_IF_ID    = 1'b1;
                    flush_ID_EX    = 1'b1;
                    redirect_taken = 1'b1;
                end else if (load_use) begin
                    stall_PC       = 1'b1;
                    stall_IF_ID    = 1'b1;
                    flush_ID_EX    = 1'b1;
                    load_use_taken = 1'b1;
                end

                if (halt_req && !mem_wait) begin
                    state_d = ST_DRAIN;
                    drain_d = '0;
                end
            end

            ST_DRAIN: begin
                if (mem_wait) begin
                    stall_PC     = 1'b1;
                    stall_IF_ID  = 1'b1;
                    stall_ID_EX  = 1'b1;
                    stall_EX_MEM = 1'b1;
                    flush_MEM_WB = 1'b1;
                end else if (redirect_EX) begin
                    // Let the PC take the target so it is correct on resume
                    flush_IF_ID    = 1'b1;
                    flush_ID_EX    = 1'b1;
                    redirect_taken = 1'b1;
                end else begin
                    stall_PC    = 1'b1;
                    flush_IF_ID = 1'b1;
                end

                if (!halt_req) begin
                    state_d = ST_RUN;
                    drain_d = '0;
                end else if (!mem_wait) begin
                    if (drain_q == DRAIN_LAST) begin
                        state_d = ST_HALTED;
                        drain_d = '0;
                    end else begin
                        drain_d = drain_q + DRAIN_ONE;
                    end
                end
            end

            ST_HALTED: begin
                stall_PC    = 1'b1;
                flush_IF_ID = 1'b1;
                if (!halt_req) begin
                    state_d = ST_RUN;
                end
            end

            default: begin
                state_d = ST_RUN;
                drain_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State, drain counter, halt acknowledge and watchdog
    // ------------------------------------------------------------------------
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_q       <= ST_RUN;
            drain_q       <= '0;
            wd_q          <= '0;
            halt_ack_q    <= 1'b0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            drain_q    <= drain_d;
            // Acknowledge tracks the state being entered so it rises and
            // falls on the same edge as the HALTED transition
            halt_ack_q <= (state_d == ST_HALTED);

            if (mem_wait) begin
                if (wd_q == WD_LAST) begin
                    mem_timeout_q <= 1'b1;
                end else begin
                    wd_q <= wd_q + WD_ONE;
                end
            end else begin
                wd_q <= '0;
            end
        end
    end

    assign halt_ack    = halt_ack_q;
    assign mem_timeout = mem_timeout_q;

    // ------------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------------
    hazard_sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk_i  (cpu_clk),
        .rst_ni (cpu_rst_n),
        .en_i   (stall_PC),
        .cnt_o  (stall_cnt)
    );

    hazard_sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk_i  (cpu_clk),
        .rst_ni (cpu_rst_n),
        .en_i   (redirect_taken),
        .cnt_o  (flush_cnt)
    );

    hazard_sat_counter #(.WIDTH(CNT_WIDTH)) u_lu_cnt (
        .clk_i  (cpu_clk),
        .rst_ni (cpu_rst_n),
        .en_i   (load_use_taken),
        .cnt_o  (lu_cnt)
    );

endmodule
`default_nettype wire
